// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / load / PC+4 result and drives the register-file
// write port, with load-response timeout, sticky error flag and retire counter.
module wb_stage #(
    parameter int unsigned LOAD_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic             in_regwen,
    input  logic [1:0]       in_wbsel,
    input  logic [31:0]      in_alu,
    input  logic [31:0]      in_pc4,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [4:0]       AddrD,
    output logic [31:0]      DataD,
    output logic             RegWEn,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } state_e;

    localparam logic [15:0] TIMER_LAST = 16'(LOAD_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [4:0]         rd_q, rd_d;
    logic               regwen_q, regwen_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic [15:0]        timer_q, timer_d;
    logic [4:0]         addrd_q, addrd_d;
    logic [31:0]        datad_q, datad_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               accept;

    function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                             input logic [1:0]  lo,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'h0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = word;
        endcase
    endfunction

    assign in_ready = (state_q != WAIT_LOAD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        regwen_d  = regwen_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        timer_d   = timer_q;
        addrd_d   = addrd_q;
        datad_d   = datad_q;
        err_d     = err_q;
        instret_d = instret_q;

        case (state_q)
            IDLE, WRITE: begin
                if (state_q == WRITE) begin
                    instret_d = instret_q + CNT_W'(1);
                end
                if (accept) begin
                    rd_d      = in_rd;
                    regwen_d  = in_regwen;
                    funct3_d  = in_funct3;
                    addr_lo_d = in_addr_lo;
                    if (in_wbsel == 2'd1) begin
                        timer_d = '0;
                        state_d = WAIT_LOAD;
                    end else begin
                        datad_d = (in_wbsel == 2'd2) ? in_pc4 : in_alu;
                        addrd_d = in_rd;
                        state_d = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOAD: begin
                // Response on the final wait edge still beats the timeout.
                if (mem_rvalid) begin
                    datad_d = load_ext(funct3_q, addr_lo_q, mem_rdata);
                    addrd_d = rd_q;
                    state_d = WRITE;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            regwen_q  <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            timer_q   <= '0;
            addrd_q   <= '0;
            datad_q   <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            regwen_q  <= regwen_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            timer_q   <= timer_d;
            addrd_q   <= addrd_d;
            datad_q   <= datad_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    assign AddrD   = addrd_q;
    assign DataD   = datad_q;
    assign RegWEn  = (state_q == WRITE) && regwen_q && (addrd_q != '0);
    assign err     = err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios plus randomized instruction stream
// checked against a transaction-level writeback model.
module tb_wb_stage;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_rd = '0;
    logic          in_regwen = 1'b0;
    logic [1:0]    in_wbsel = '0;
    logic [31:0]   in_alu = '0;
    logic [31:0]   in_pc4 = '0;
    logic [2:0]    in_funct3 = '0;
    logic [1:0]    in_addr_lo = '0;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic [4:0]    AddrD;
    logic [31:0]   DataD;
    logic          RegWEn;
    logic          err;
    logic [CW-1:0] instret;

    wb_stage #(.LOAD_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_regwen(in_regwen), .in_wbsel(in_wbsel),
        .in_alu(in_alu), .in_pc4(in_pc4), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .AddrD(AddrD), .DataD(DataD), .RegWEn(RegWEn),
        .err(err), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned exp_instret = 0;
    logic        exp_err = 1'b0;
    int          n_checks = 0;
    int          n_errs = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(lo))) & 32'hFF;
        h = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Every register-file write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        wr_t e;
        if (RegWEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("stray_write", RegWEn, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", AddrD, e.addr);
                chk("wr_data", DataD, e.data);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_addrd", AddrD, 0);
        chk("rst_datad", DataD, 0);
        chk("rst_regwen", RegWEn, 0);
        chk("rst_err", err, 0);
        chk("rst_instret", instret, 0);
        chk("rst_ready", in_ready, 1);
        exp_q.delete();
        exp_instret = 0;
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic gap();
        in_valid   = 1'b0;
        in_rd      = 5'($urandom);
        in_wbsel   = 2'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge inside the WRITE cycle (or after timeout).
    task automatic send(input logic [4:0] rd, input logic rw, input logic [1:0] ws,
                        input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [31:0] rdata, input int unsigned delay);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_regwen  = rw;
        in_wbsel   = ws;
        in_funct3  = f3;
        in_addr_lo = lo;
        in_alu     = alu;
        in_pc4     = pc4;
        chk("in_ready_accept", in_ready, 1);
        if (ws == 2'd1) begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (delay < T) begin
                if (rw && rd != 0) exp_q.push_back('{addr: rd, data: ref_load(f3, lo, rdata)});
                exp_instret++;
            end else begin
                exp_err = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_rd    = 5'($urandom);
            for (int unsigned i = 0; i < delay && i < T; i++) begin
                chk("in_ready_wait", in_ready, 0);
                mem_rdata = $urandom;
                @(negedge clk);
            end
            if (delay < T) begin
                chk("in_ready_wait", in_ready, 0);
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end else begin
                chk("in_ready_timeout", in_ready, 1);
                chk("err_timeout", err, 1);
            end
        end else begin
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            if (rw && rd != 0) exp_q.push_back('{addr: rd, data: (ws == 2'd2) ? pc4 : alu});
            exp_instret++;
            @(posedge clk);
            @(negedge clk);
            in_valid   = 1'b0;
            mem_rvalid = 1'b0;
        end
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("instret", instret, exp_instret % (1 << CW));
        chk("err", err, exp_err);
        chk("writes_pending", exp_q.size(), 0);
    endtask

    initial begin
        // 1: single ALU op
        do_reset();
        send(5'd5, 1'b1, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 0);
        chk("t1_addrd", AddrD, 5);
        chk("t1_datad", DataD, 32'h1234_5678);
        chk("t1_regwen", RegWEn, 1);
        @(negedge clk);
        chk("t1_instret", instret, 1);

        // 2: back-to-back ALU ops
        do_reset();
        send(5'd1, 1'b1, 2'd0, 3'd0, 2'd0, 32'hA1, 32'h0, 32'h0, 0);
        send(5'd2, 1'b1, 2'd3, 3'd0, 2'd0, 32'hA2, 32'h0, 32'h0, 0);
        send(5'd3, 1'b1, 2'd0, 3'd0, 2'd0, 32'hA3, 32'h0, 32'h0, 0);
        drain();

        // 3: LB / LHU; delay T-1 puts rvalid on the same edge the timeout would fire
        do_reset();
        send(5'd9, 1'b1, 2'd1, 3'b000, 2'd3, 32'h0, 32'h0, 32'h80FF_0000, T - 1);
        chk("t3_lb", DataD, 32'hFFFF_FF80);
        send(5'd10, 1'b1, 2'd1, 3'b101, 2'd2, 32'h0, 32'h0, 32'h80FF_0000, 1);
        chk("t3_lhu", DataD, 32'h0000_80FF);
        drain();

        // 4: PC+4 to x0
        do_reset();
        send(5'd0, 1'b1, 2'd2, 3'd0, 2'd0, 32'h0, 32'h100, 32'h0, 0);
        chk("t4_regwen", RegWEn, 0);
        drain();

        // 5: load timeout
        do_reset();
        send(5'd4, 1'b1, 2'd0, 3'd0, 2'd0, 32'h55, 32'h0, 32'h0, 0);
        send(5'd6, 1'b1, 2'd1, 3'b010, 2'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 10);
        drain();

        // 6: reset while waiting on a load
        do_reset();
        send(5'd7, 1'b1, 2'd0, 3'd0, 2'd0, 32'hCAFE, 32'h0, 32'h0, 0);
        drain();
        in_valid   = 1'b1;
        in_rd      = 5'd8;
        in_regwen  = 1'b1;
        in_wbsel   = 2'd1;
        in_funct3  = 3'b010;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_addrd", AddrD, 0);
        chk("t6_datad", DataD, 0);
        chk("t6_regwen", RegWEn, 0);
        chk("t6_instret", instret, 0);
        chk("t6_ready", in_ready, 1);
        exp_q.delete();
        exp_instret = 0;
        exp_err = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        drain();

        // Random stream; long enough to wrap the counter
        do_reset();
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) gap();
            send(5'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
                 $urandom, $urandom, $urandom, $urandom_range(0, T + 1));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
